// File: rtl/rb_window_scheduler.sv
// rb_window_scheduler: control sequencer for the row-buffer bank array.
// The incoming pixel stream is written round-robin into RB_COUNT one-row banks.
// KERNEL-row windows are read column by column for the downstream window mux.
// A write never overwrites a bank whose row a pending window still needs.
// The block holds no pixel data.
// Optional build macro RB_SCHED_STATS_EN adds the stall counters in_stall_cnt
// and out_stall_cnt.
module rb_window_scheduler #(
  parameter int unsigned IMAGE_WIDTH  = 256,
  parameter int unsigned IMAGE_HEIGHT = 256,
  parameter int unsigned RB_COUNT     = 8,
  parameter int unsigned KERNEL       = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            wr_en,
  output logic [$clog2(RB_COUNT)-1:0]     wr_bank,
  output logic [$clog2(IMAGE_WIDTH)-1:0]  wr_addr,
  output logic                            rd_en,
  output logic [$clog2(IMAGE_WIDTH)-1:0]  rd_addr,
  output logic [$clog2(RB_COUNT)-1:0]     rd_base_bank,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy,
  output logic                            frame_done
`ifdef RB_SCHED_STATS_EN
  ,
  output logic [31:0]                     in_stall_cnt,
  output logic [31:0]                     out_stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(IMAGE_WIDTH);
  localparam int unsigned BW = $clog2(RB_COUNT);
  localparam int unsigned RW = $clog2(IMAGE_HEIGHT + 1);
  // Wide enough for row + RB_COUNT / row + KERNEL sums without wrapping
  localparam int unsigned XW = ((RW > BW) ? RW : BW) + 2;

  localparam logic [CW-1:0] COL_LAST     = CW'(IMAGE_WIDTH - 1);
  localparam logic [BW-1:0] BANK_LAST    = BW'(RB_COUNT - 1);
  localparam logic [RW-1:0] OUT_ROW_LAST = RW'(IMAGE_HEIGHT - KERNEL);
  localparam logic [RW-1:0] ROW_COUNT    = RW'(IMAGE_HEIGHT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] wcol;
  logic [CW-1:0] rcol;
  logic [RW-1:0] wrow;
  logic [RW-1:0] orow;
  logic [RW-1:0] retired;
  logic          out_row_end;

  logic run;
  logic readable;
  logic accept;

  // Handshake strobes, all derived from registered state plus the live valid/ready inputs
  assign run      = (state == RUN);
  assign in_ready = run && (wrow < ROW_COUNT) &&
                    (XW'(wrow) < (XW'(retired) + XW'(RB_COUNT)));
  assign wr_en    = in_valid && in_ready;
  assign readable = (XW'(wrow) >= (XW'(orow) + XW'(KERNEL)));
  assign rd_en    = run && readable && (!out_valid || out_ready);
  assign accept   = out_valid && out_ready;
  assign wr_addr  = wcol;
  assign rd_addr  = rcol;

  // Frame FSM, write/read position counters and registered output-side status
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wcol         <= '0;
      wrow         <= '0;
      wr_bank      <= '0;
      rcol         <= '0;
      orow         <= '0;
      rd_base_bank <= '0;
      retired      <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_row_end  <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= RUN;
            busy         <= 1'b1;
            wcol         <= '0;
            wrow         <= '0;
            wr_bank      <= '0;
            rcol         <= '0;
            orow         <= '0;
            rd_base_bank <= '0;
            retired      <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_row_end  <= 1'b0;
          end
        end
        RUN: begin
          if (wr_en) begin
            if (wcol == COL_LAST) begin
              wcol    <= '0;
              wrow    <= wrow + RW'(1);
              wr_bank <= (wr_bank == BANK_LAST) ? '0 : wr_bank + BW'(1);
            end else begin
              wcol <= wcol + CW'(1);
            end
          end
          if (rd_en) begin
            out_valid   <= 1'b1;
            out_last    <= (orow == OUT_ROW_LAST) && (rcol == COL_LAST);
            out_row_end <= (rcol == COL_LAST);
            if (rcol == COL_LAST) begin
              rcol         <= '0;
              orow         <= orow + RW'(1);
              rd_base_bank <= (rd_base_bank == BANK_LAST) ? '0 : rd_base_bank + BW'(1);
            end else begin
              rcol <= rcol + CW'(1);
            end
          end else if (accept) begin
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_row_end <= 1'b0;
          end
          // Credit from a retiring row only reaches in_ready on the next cycle
          if (accept && out_row_end) begin
            retired <= retired + RW'(1);
          end
          if (accept && out_last) begin
            state      <= DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef RB_SCHED_STATS_EN
  // Saturating stall counters, cleared by reset and at each frame start
  always_ff @(posedge clk) begin
    if (rst || ((state == IDLE) && start)) begin
      in_stall_cnt  <= '0;
      out_stall_cnt <= '0;
    end else begin
      if (run && in_valid && !in_ready && (in_stall_cnt != '1)) begin
        in_stall_cnt <= in_stall_cnt + 32'd1;
      end
      if (out_valid && !out_ready && (out_stall_cnt != '1)) begin
        out_stall_cnt <= out_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
